alu_ctrl_stage: RTL and testbench

Registered, parametrised ALU control decode stage between ID and EX. Decodes the 11-bit instruction opcode into an ALU control code and holds it in a single-entry pipeline register with a valid/ready handshake and flush. It extends the current decode set with logical, shift and multi-cycle MUL operations, blocks issue while the multiplier is occupied, and flags and counts unsupported opcodes.

---
 rtl/alu_ctrl_stage.sv | 189 ++++++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// alu_ctrl_stage
//
// Registered ALU control decode stage sitting between ID and EX. The 11-bit
// opcode (instruction bits [31:21]) is decoded into an ALU control code and
// captured in a single-entry pipeline register guarded by a valid/ready
// handshake. Multi-cycle MUL operations occupy the multiplier for MUL_CYCLES
// cycles after hand-off; during that time no new instruction is issued.
// Unsupported opcodes are flagged, and those handed to EX are counted.
//
// Parameters
//   CTRL_W      ALU control code width (>= 4); codes are zero-extended.
//   MUL_CYCLES  EX occupancy of a MUL in cycles (>= 1).
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   opcode_in      instruction bits [31:21]
//   alu_on_in      instruction uses the ALU
//   valid_in       upstream presents an instruction
//   ready_out      stage accepts this cycle (combinational, never from valid_in/flush)
//   flush          squash the held entry and any same-cycle input
//   valid_out      entry held for EX
//   ready_in       EX accepts this cycle
//   alu_cntrl_out  registered ALU control code
//   illegal_out    held entry is an unsupported opcode
//   mul_busy       multiplier occupied, issue blocked
//   illegal_seen   sticky: an illegal entry was handed to EX
//   err_count      saturating count of illegal entries handed to EX
// -----------------------------------------------------------------------------
module alu_ctrl_stage #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       opcode_in,
    input  logic              alu_on_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              flush,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] alu_cntrl_out,
    output logic              illegal_out,
    output logic              mul_busy,
    output logic              illegal_seen,
    output logic [7:0]        err_count
);

    // A MUL only occupies the multiplier beyond its hand-off cycle when it
    // takes more than one cycle; otherwise it is treated like any other op.
    localparam bit MULTI = (MUL_CYCLES > 1);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } stateT;

    stateT             stateReg;
    logic [CNT_W-1:0]  cntReg;
    logic              validReg;
    logic [CTRL_W-1:0] ctrlReg;
    logic              illegalReg;
    logic              isMulReg;
    logic              illegalSeenReg;
    logic [7:0]        errCountReg;

    logic [CTRL_W-1:0] decCode;
    logic              decIllegal;
    logic              decIsMul;
    logic              accept;
    logic              handoff;
    logic              busy;

    // ------------------------------------------------------------------
    // Opcode decode. Patterns are mutually disjoint.
    // ------------------------------------------------------------------
    always_comb begin
        decCode    = '0;
        decIllegal = 1'b0;
        decIsMul   = 1'b0;
        if (alu_on_in) begin
            casez (opcode_in)
                11'b1001000100?,                          // ADDI
                11'b10101011000,                          // ADDS
                11'b11111000010,                          // LDUR
                11'b11111000000: decCode = CTRL_W'(4'b0010); // STUR
                11'b11101011000: decCode = CTRL_W'(4'b0011); // SUBS
                11'b100101?????: decCode = CTRL_W'(4'b0000); // BL
                11'b10110100???: decCode = CTRL_W'(4'b0100); // CBZ
                11'b10001010000: decCode = CTRL_W'(4'b0101); // AND
                11'b10101010000: decCode = CTRL_W'(4'b0110); // ORR
                11'b11001010000: decCode = CTRL_W'(4'b0111); // EOR
                11'b11010011011: decCode = CTRL_W'(4'b1000); // LSL
                11'b11010011010: decCode = CTRL_W'(4'b1001); // LSR
                11'b10011011000: begin                       // MUL
                    decCode  = CTRL_W'(4'b1010);
                    decIsMul = 1'b1;
                end
                default: begin
                    decCode    = '1;
                    decIllegal = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake. A held multi-cycle MUL must leave before anything else
    // is accepted, so it never allows pass-through acceptance.
    // ------------------------------------------------------------------
    assign busy      = (stateReg == BUSY);
    assign ready_out = !busy && (!validReg || (ready_in && !(isMulReg && MULTI)));
    assign accept    = valid_in && ready_out;
    assign handoff   = validReg && ready_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg       <= IDLE;
            cntReg         <= '0;
            validReg       <= 1'b0;
            ctrlReg        <= '0;
            illegalReg     <= 1'b0;
            isMulReg       <= 1'b0;
            illegalSeenReg <= 1'b0;
            errCountReg    <= '0;
        end else begin
            // Pipeline entry. Flush wins over both accept and hand-off.
            if (flush) begin
                validReg   <= 1'b0;
                ctrlReg    <= '0;
                illegalReg <= 1'b0;
                isMulReg   <= 1'b0;
            end else if (accept) begin
                validReg   <= 1'b1;
                ctrlReg    <= decCode;
                illegalReg <= decIllegal;
                isMulReg   <= decIsMul;
            end else if (handoff) begin
                validReg   <= 1'b0;
                ctrlReg    <= '0;
                illegalReg <= 1'b0;
                isMulReg   <= 1'b0;
            end

            // Multiplier occupancy. A flushed hand-off is squashed and
            // does not start the multiplier; an already running count is
            // unaffected by flush.
            case (stateReg)
                IDLE: begin
                    if (handoff && !flush && isMulReg && MULTI) begin
                        stateReg <= BUSY;
                        cntReg   <= CNT_W'(MUL_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (cntReg == CNT_W'(1)) begin
                        stateReg <= IDLE;
                        cntReg   <= '0;
                    end else begin
                        cntReg <= cntReg - CNT_W'(1);
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    cntReg   <= '0;
                end
            endcase

            // Error tracking on real (non-flushed) hand-offs only.
            if (handoff && !flush && illegalReg) begin
                illegalSeenReg <= 1'b1;
                if (errCountReg != 8'hFF) begin
                    errCountReg <= errCountReg + 8'd1;
                end
            end
        end
    end

    assign valid_out     = validReg;
    assign alu_cntrl_out = ctrlReg;
    assign illegal_out   = illegalReg;
    assign mul_busy      = busy;
    assign illegal_seen  = illegalSeenReg;
    assign err_count     = errCountReg;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_stage
//
// Self-checking bench for alu_ctrl_stage (CTRL_W=4, MUL_CYCLES=4). Directed
// scenario tasks check constant expectations; a behavioural model (opcode
// mask/pattern table, entry slot, remaining-busy-cycles counter, error
// tally) tracks every clock and is compared against the DUT during the
// randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_stage;

    localparam int CW   = 4;
    localparam int MULC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   opcode_in;
    logic          alu_on_in;
    logic          valid_in;
    logic          ready_out;
    logic          flush;
    logic          valid_out;
    logic          ready_in;
    logic [CW-1:0] alu_cntrl_out;
    logic          illegal_out;
    logic          mul_busy;
    logic          illegal_seen;
    logic [7:0]    err_count;

    int errors = 0;
    int checks = 0;

    alu_ctrl_stage #(.CTRL_W(CW), .MUL_CYCLES(MULC)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode_in    (opcode_in),
        .alu_on_in    (alu_on_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .flush        (flush),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .alu_cntrl_out(alu_cntrl_out),
        .illegal_out  (illegal_out),
        .mul_busy     (mul_busy),
        .illegal_seen (illegal_seen),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Opcode table: (opcode & mask) == pattern selects the code.
    localparam int NOPS = 13;
    localparam logic [10:0] T_MASK [NOPS] = '{
        11'b11111111110, 11'b11111111111, 11'b11111111111, 11'b11111111111,
        11'b11111111111, 11'b11111100000, 11'b11111111000, 11'b11111111111,
        11'b11111111111, 11'b11111111111, 11'b11111111111, 11'b11111111111,
        11'b11111111111};
    localparam logic [10:0] T_PAT [NOPS] = '{
        11'b10010001000, 11'b10101011000, 11'b11111000010, 11'b11111000000,
        11'b11101011000, 11'b10010100000, 11'b10110100000, 11'b10001010000,
        11'b10101010000, 11'b11001010000, 11'b11010011011, 11'b11010011010,
        11'b10011011000};
    localparam logic [3:0] T_CODE [NOPS] = '{
        4'h2, 4'h2, 4'h2, 4'h2, 4'h3, 4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};

    localparam logic [10:0] OP_ADDI = 11'b10010001001;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_MUL  = 11'b10011011000;

    // ---------------- behavioural model state ----------------
    bit       mValid;
    bit [3:0] mCode;
    bit       mIll;
    bit       mIsMul;
    int       mBusyLeft;
    bit       mSeen;
    int       mErr;

    function automatic void refDecode(input logic [10:0] opc, input logic aluOn,
                                      output bit [3:0] code, output bit ill, output bit isMul);
        code  = 4'h0;
        ill   = 1'b0;
        isMul = 1'b0;
        if (aluOn) begin
            code = 4'hF;
            ill  = 1'b1;
            for (int i = 0; i < NOPS; i++) begin
                if ((opc & T_MASK[i]) == T_PAT[i]) begin
                    code  = T_CODE[i];
                    ill   = 1'b0;
                    isMul = (i == NOPS - 1);
                end
            end
        end
    endfunction

    function automatic bit modelReady();
        return (mBusyLeft == 0) && (!mValid || (ready_in && !(mIsMul && MULC > 1)));
    endfunction

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        bit [3:0] c;
        bit il, mu, acc, hand;
        refDecode(opcode_in, alu_on_in, c, il, mu);
        acc  = valid_in && modelReady();
        hand = mValid && ready_in;
        if (reset) begin
            mValid = 0; mCode = 0; mIll = 0; mIsMul = 0;
            mBusyLeft = 0; mSeen = 0; mErr = 0;
        end else begin
            if (mBusyLeft > 0) mBusyLeft--;
            if (hand && !flush) begin
                if (mIll) begin
                    mSeen = 1;
                    if (mErr < 255) mErr++;
                end
                if (mIsMul && MULC > 1) mBusyLeft = MULC - 1;
            end
            if (flush) begin
                mValid = 0; mCode = 0; mIll = 0; mIsMul = 0;
            end else if (acc) begin
                mValid = 1; mCode = c; mIll = il; mIsMul = mu;
            end else if (hand) begin
                mValid = 0; mCode = 0; mIll = 0; mIsMul = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        valid_in = 0; flush = 0; ready_in = 1; alu_on_in = 1; opcode_in = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; idleInputs();
        tick(); tick();
        reset = 0;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
        checks++; if (alu_cntrl_out !== 4'h0) begin errors++; $display("FAIL reset_code: got %0h want 0", alu_cntrl_out); end
        checks++; if ({illegal_out, mul_busy, illegal_seen} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %03b want 000", {illegal_out, mul_busy, illegal_seen}); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", ready_out); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        logic [10:0] ops [4];
        logic [3:0]  want [4];
        ops  = '{OP_ADDS, OP_SUBS, OP_AND, OP_LSR};
        want = '{4'h2, 4'h3, 4'h5, 4'h9};
        idleInputs();
        for (int i = 0; i < 4; i++) begin
            opcode_in = ops[i]; valid_in = 1;
            #1;
            checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, ready_out); end
            tick();
            checks++; if ({valid_out, alu_cntrl_out} !== {1'b1, want[i]}) begin
                errors++; $display("FAIL b2b_code[%0d]: got v=%0b c=%0h want v=1 c=%0h", i, valid_out, alu_cntrl_out, want[i]);
            end
            $display("b2b op=%b code=%0h", ops[i], alu_cntrl_out);
        end
        valid_in = 0; tick();
    endtask

    task automatic test_mul();
        int n;
        idleInputs();
        opcode_in = OP_MUL; valid_in = 1;
        tick();
        checks++; if ({valid_out, alu_cntrl_out} !== {1'b1, 4'hA}) begin errors++; $display("FAIL mul_held: got v=%0b c=%0h want v=1 c=a", valid_out, alu_cntrl_out); end
        opcode_in = OP_ADDI;
        #1;
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mul_hold_ready: got %0b want 0", ready_out); end
        tick();
        checks++; if ({valid_out, mul_busy} !== 2'b01) begin errors++; $display("FAIL mul_handoff: got v=%0b busy=%0b want v=0 busy=1", valid_out, mul_busy); end
        n = 0;
        while (mul_busy === 1'b1 && n < 10) begin
            checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mul_busy_ready[%0d]: got %0b want 0", n, ready_out); end
            tick(); n++;
        end
        checks++; if (n != MULC - 1) begin errors++; $display("FAIL mul_busy_len: got %0d want %0d", n, MULC - 1); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL mul_ready_back: got %0b want 1", ready_out); end
        tick();
        checks++; if ({valid_out, alu_cntrl_out} !== {1'b1, 4'h2}) begin errors++; $display("FAIL mul_next_addi: got v=%0b c=%0h want v=1 c=2", valid_out, alu_cntrl_out); end
        $display("mul busy_cycles=%0d next_code=%0h", n, alu_cntrl_out);
        valid_in = 0; tick();
    endtask

    task automatic test_backpressure();
        idleInputs();
        opcode_in = OP_CBZ; valid_in = 1; ready_in = 0;
        tick();
        opcode_in = OP_SUBS;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, ready_out); end
            checks++; if ({valid_out, alu_cntrl_out} !== {1'b1, 4'h4}) begin errors++; $display("FAIL bp_stable[%0d]: got v=%0b c=%0h want v=1 c=4", i, valid_out, alu_cntrl_out); end
            tick();
        end
        ready_in = 1;
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", ready_out); end
        tick();
        checks++; if ({valid_out, alu_cntrl_out} !== {1'b1, 4'h3}) begin errors++; $display("FAIL bp_subs: got v=%0b c=%0h want v=1 c=3", valid_out, alu_cntrl_out); end
        $display("backpressure released code=%0h", alu_cntrl_out);
        valid_in = 0; tick();
    endtask

    task automatic test_flush();
        idleInputs();
        opcode_in = 11'd0; valid_in = 1; ready_in = 0;
        tick();
        checks++; if ({valid_out, illegal_out, alu_cntrl_out} !== {2'b11, 4'hF}) begin errors++; $display("FAIL flush_setup: got v=%0b i=%0b c=%0h want v=1 i=1 c=f", valid_out, illegal_out, alu_cntrl_out); end
        opcode_in = OP_ORR; ready_in = 1; flush = 1;
        tick();
        flush = 0; valid_in = 0;
        checks++; if ({valid_out, illegal_out, alu_cntrl_out} !== 6'b0) begin errors++; $display("FAIL flush_clear: got v=%0b i=%0b c=%0h want all 0", valid_out, illegal_out, alu_cntrl_out); end
        checks++; if ({illegal_seen, err_count} !== 9'd0) begin errors++; $display("FAIL flush_nocount: got seen=%0b cnt=%0d want 0/0", illegal_seen, err_count); end
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_orr_dropped: got %0b want 0", valid_out); end
        $display("flush valid_out=%0b err_count=%0d", valid_out, err_count);
    endtask

    task automatic test_alu_off();
        idleInputs();
        opcode_in = OP_ADDS; alu_on_in = 0; valid_in = 1;
        tick();
        checks++; if ({valid_out, illegal_out, alu_cntrl_out} !== {2'b10, 4'h0}) begin errors++; $display("FAIL alu_off: got v=%0b i=%0b c=%0h want v=1 i=0 c=0", valid_out, illegal_out, alu_cntrl_out); end
        $display("alu_off code=%0h illegal=%0b", alu_cntrl_out, illegal_out);
        valid_in = 0; alu_on_in = 1; tick();
    endtask

    task automatic test_illegal_sat();
        int bad = 0;
        int want;
        idleInputs();
        opcode_in = 11'd0; valid_in = 1;
        for (int k = 1; k <= 301; k++) begin
            tick();
            want = (k - 1 > 255) ? 255 : k - 1;
            if (!(valid_out === 1'b1 && alu_cntrl_out === 4'hF && illegal_out === 1'b1 && err_count == 8'(want))) begin
                if (bad < 3) $display("ill k=%0d v=%0b c=%0h i=%0b cnt=%0d want_cnt=%0d", k, valid_out, alu_cntrl_out, illegal_out, err_count, want);
                bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ill_stream: got %0d bad cycles want 0", bad); end
        checks++; if ({illegal_seen, err_count} !== {1'b1, 8'd255}) begin errors++; $display("FAIL ill_saturate: got seen=%0b cnt=%0d want 1/255", illegal_seen, err_count); end
        $display("illegal stream err_count=%0d seen=%0b", err_count, illegal_seen);
        valid_in = 0; tick();
    endtask

    task automatic test_reset_busy();
        idleInputs();
        opcode_in = OP_MUL; valid_in = 1;
        tick();
        valid_in = 0;
        tick();
        checks++; if (mul_busy !== 1'b1) begin errors++; $display("FAIL rb_busy: got %0b want 1", mul_busy); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if ({mul_busy, ready_out, err_count} !== {2'b01, 8'd0}) begin errors++; $display("FAIL rb_after: got busy=%0b ready=%0b cnt=%0d want 0/1/0", mul_busy, ready_out, err_count); end
        $display("reset in busy mul_busy=%0b ready_out=%0b", mul_busy, ready_out);
    endtask

    task automatic test_random();
        int bad = 0;
        int idx;
        for (int i = 0; i < 500; i++) begin
            idx = $urandom_range(0, NOPS + 3);
            opcode_in = (idx < NOPS) ? (T_PAT[idx] | (11'($urandom) & ~T_MASK[idx])) : 11'($urandom);
            alu_on_in = ($urandom_range(0, 9) != 0);
            valid_in  = ($urandom_range(0, 3) != 0);
            ready_in  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            #1;
            checks++; if (ready_out !== modelReady()) begin errors++; bad++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, ready_out, modelReady()); end
            tick();
            checks++;
            if ({valid_out, alu_cntrl_out, illegal_out, mul_busy, illegal_seen, err_count} !==
                {mValid, mCode, mIll, (mBusyLeft > 0), mSeen, 8'(mErr)}) begin
                errors++; bad++;
                $display("FAIL rnd_out[%0d]: got v=%0b c=%0h i=%0b b=%0b s=%0b n=%0d want v=%0b c=%0h i=%0b b=%0b s=%0b n=%0d",
                         i, valid_out, alu_cntrl_out, illegal_out, mul_busy, illegal_seen, err_count,
                         mValid, mCode, mIll, (mBusyLeft > 0), mSeen, mErr);
            end
            if (bad > 10) break;
        end
        reset = 0; idleInputs();
        $display("random phase mismatching cycles=%0d", bad);
    endtask

    initial begin
        reset = 1;
        idleInputs();
        test_reset();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_flush();
        test_alu_off();
        test_illegal_sat();
        test_reset_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
